// File: rtl/rr_arb_enc16_if.sv
// Request/grant bundle between the requesters and the rr_arb_enc16 arbiter.
interface rr_arb_enc16_if;
    logic        enable;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;

    modport master (
        output enable,
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  enable,
        input  req,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface

// File: rtl/rr_arb_enc16.sv
// 16-way round-robin arbiter with held (non-preemptive) one-hot grant and binary index.
// Optional hold limit: define RR_ARB_HOLD_LIMIT_EN to bound ownership to MAX_HOLD cycles.
module rr_arb_enc16 #(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arb_enc16_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  ptr_reg, ptr_next;
    logic [15:0] grant_reg, grant_next;
    logic [3:0]  idx_reg, idx_next;
    logic        valid_reg, valid_next;

    logic [3:0]  search_start;
    logic [15:0] own_mask;
    logic [15:0] cand;
    logic [15:0] rot;
    logic        win_found;
    logic [3:0]  win_off;
    logic [3:0]  win_idx;
    logic [15:0] win_onehot;
    logic        force_release;

    // While granted, the search starts just past the owner and ignores its bit,
    // so a re-asserting owner lands at the back of the queue.
    assign search_start = (state_reg == GRANT) ? idx_reg + 4'd1 : ptr_reg;
    assign own_mask     = (state_reg == GRANT) ? (16'h0001 << idx_reg) : 16'h0000;
    assign cand         = bus.req & ~own_mask;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rot
            localparam logic [3:0] OFF = 4'(gi);
            assign rot[gi] = cand[search_start + OFF];
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_off   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (rot[i]) begin
                win_found = 1'b1;
                win_off   = 4'(i);
            end
        end
    end

    assign win_idx    = search_start + win_off;
    assign win_onehot = 16'h0001 << win_idx;

`ifdef RR_ARB_HOLD_LIMIT_EN
    logic [7:0] hold_reg, hold_next;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    // cand already excludes the owner, so any bit set means someone else waits.
    assign force_release = (hold_reg == HOLD_LAST) && win_found;
`else
    logic [7:0] unused_max_hold;
    assign unused_max_hold = 8'(MAX_HOLD);
    assign force_release   = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
`ifdef RR_ARB_HOLD_LIMIT_EN
        hold_next  = hold_reg;
`endif
        if (!bus.enable) begin
            state_next = IDLE;
            grant_next = 16'h0000;
            idx_next   = 4'd0;
            valid_next = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_next  = 8'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_next = GRANT;
                        grant_next = win_onehot;
                        idx_next   = win_idx;
                        valid_next = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
                        hold_next  = 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (bus.req[idx_reg] && !force_release) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
                        if (hold_reg < HOLD_LAST)
                            hold_next = hold_reg + 8'd1;
`endif
                    end else begin
                        ptr_next = idx_reg + 4'd1;
                        if (win_found) begin
                            grant_next = win_onehot;
                            idx_next   = win_idx;
                            valid_next = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
                            hold_next  = 8'd0;
`endif
                        end else begin
                            state_next = IDLE;
                            grant_next = 16'h0000;
                            idx_next   = 4'd0;
                            valid_next = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
                            hold_next  = 8'd0;
`endif
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    grant_next = 16'h0000;
                    idx_next   = 4'd0;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 4'd0;
            grant_reg <= 16'h0000;
            idx_reg   <= 4'd0;
            valid_reg <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_reg  <= 8'd0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_reg  <= hold_next;
`endif
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.grant_idx   = idx_reg;
    assign bus.grant_valid = valid_reg;

endmodule
